// File: rtl/lamp_pkg.sv
// Shared encodings, phase limits and lamp patterns for the lamp sequencer.
package lamp_pkg;

  typedef enum logic [1:0] {
    MODE_AUTO  = 2'b00,
    MODE_FLASH = 2'b01,
    MODE_CHASE = 2'b10,
    MODE_ALT   = 2'b11
  } mode_e;

  localparam logic [2:0] LAST_FLASH = 3'd1;
  localparam logic [2:0] LAST_CHASE = 3'd7;
  localparam logic [2:0] LAST_ALT   = 3'd1;

  localparam logic [7:0] PAT_FLASH_0 = 8'h00;
  localparam logic [7:0] PAT_FLASH_1 = 8'hFF;
  localparam logic [7:0] PAT_ALT_0   = 8'h55;
  localparam logic [7:0] PAT_ALT_1   = 8'hAA;
  // Indexed by phase: phase 0 lights the leftmost lamp.
  localparam logic [7:0][7:0] PAT_CHASE = {8'h01, 8'h02, 8'h04, 8'h08,
                                           8'h10, 8'h20, 8'h40, 8'h80};

  function automatic logic [2:0] last_phase(input mode_e m);
    case (m)
      MODE_CHASE: last_phase = LAST_CHASE;
      MODE_ALT:   last_phase = LAST_ALT;
      default:    last_phase = LAST_FLASH;
    endcase
  endfunction

  function automatic mode_e rotate_mode(input mode_e m);
    case (m)
      MODE_FLASH: rotate_mode = MODE_CHASE;
      MODE_CHASE: rotate_mode = MODE_ALT;
      default:    rotate_mode = MODE_FLASH;
    endcase
  endfunction

  function automatic logic [7:0] pattern(input mode_e m, input logic [2:0] ph);
    case (m)
      MODE_FLASH: pattern = ph[0] ? PAT_FLASH_1 : PAT_FLASH_0;
      MODE_CHASE: pattern = PAT_CHASE[ph];
      MODE_ALT:   pattern = ph[0] ? PAT_ALT_1 : PAT_ALT_0;
      default:    pattern = PAT_FLASH_0;
    endcase
  endfunction

endpackage

// File: rtl/lamp_tick_gen.sv
// Step-enable source: prescaled tick while running, single-step pulse while paused.
module lamp_tick_gen #(
  parameter int TICK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic step_req,
  output logic adv
);

  localparam int CW = $clog2(TICK_DIV) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;
  logic          at_last;

  assign at_last = (cnt >= CNT_LAST);
  assign adv     = run ? at_last : step_req;

  // Count holds while paused so resuming continues the interrupted interval.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  cnt <= '0;
    else if (run) cnt <= at_last ? '0 : cnt + 1'b1;
  end

endmodule

// File: rtl/lamp_seq_ctrl.sv
// Lamp pattern sequencer: mode/phase/repeat state, registered lamp bus and tick.
module lamp_seq_ctrl
  import lamp_pkg::*;
#(
  parameter int TICK_DIV = 4,
  parameter int REPEAT   = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic       step_req,
  input  logic [1:0] mode_sel,
  output logic [7:0] lamb,
  output logic [1:0] mode,
  output logic       tick
);

  localparam int RW = $clog2(REPEAT) + 1;
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT - 1);

  logic          adv;
  mode_e         mode_q, nxt_mode, sel;
  logic [2:0]    phase, nxt_phase;
  logic [RW-1:0] rep, nxt_rep;

  lamp_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .run      (run),
    .step_req (step_req),
    .adv      (adv)
  );

  assign sel  = mode_e'(mode_sel);
  assign mode = mode_q;

  always_comb begin
    nxt_mode  = mode_q;
    nxt_phase = phase;
    nxt_rep   = rep;
    if (sel != MODE_AUTO && sel != mode_q) begin
      nxt_mode  = sel;
      nxt_phase = '0;
      nxt_rep   = '0;
    end else if (mode_q == MODE_AUTO || phase > last_phase(mode_q)) begin
      // Corrupted state: fall back to a known-good display.
      nxt_mode  = MODE_FLASH;
      nxt_phase = '0;
      nxt_rep   = '0;
    end else if (phase < last_phase(mode_q)) begin
      nxt_phase = phase + 3'd1;
    end else if (sel == MODE_AUTO && rep >= REP_LAST) begin
      nxt_mode  = rotate_mode(mode_q);
      nxt_phase = '0;
      nxt_rep   = '0;
    end else begin
      nxt_phase = '0;
      nxt_rep   = (sel == MODE_AUTO) ? rep + 1'b1 : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= MODE_FLASH;
      phase  <= '0;
      rep    <= '0;
      lamb   <= 8'h00;
      tick   <= 1'b0;
    end else begin
      tick <= adv;
      if (adv) begin
        mode_q <= nxt_mode;
        phase  <= nxt_phase;
        rep    <= nxt_rep;
        lamb   <= pattern(nxt_mode, nxt_phase);
      end
    end
  end

endmodule

// File: tb/tb_lamp_seq_ctrl.sv
// Directed bench for lamp_seq_ctrl with hand-computed lamp/mode/tick expectations.
module tb_lamp_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       run = 1'b1;
  logic       step_req = 1'b0;
  logic [1:0] mode_sel = 2'b01;
  logic [7:0] lamb;
  logic [1:0] mode;
  logic       tick;

  int checks = 0;
  int failures = 0;

  lamp_seq_ctrl #(.TICK_DIV(4), .REPEAT(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .run      (run),
    .step_req (step_req),
    .mode_sel (mode_sel),
    .lamb     (lamb),
    .mode     (mode),
    .tick     (tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Waits (bounded) for the next tick and checks spacing, lamps and mode.
  task automatic wait_tick(input string tag, input int exp_cyc,
                           input logic [7:0] exp_lamb, input logic [1:0] exp_mode);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!tick && n < 40);
    chk({tag, ".cyc"}, n, exp_cyc);
    chk({tag, ".lamb"}, lamb, exp_lamb);
    chk({tag, ".mode"}, mode, exp_mode);
  endtask

  task automatic step_once(input string tag, input logic [7:0] exp_lamb);
    int extra;
    @(negedge clk);
    step_req = 1'b1;
    @(negedge clk);
    step_req = 1'b0;
    chk({tag, ".tick"}, tick, 1);
    chk({tag, ".lamb"}, lamb, exp_lamb);
    extra = 0;
    repeat (4) begin
      @(negedge clk);
      if (tick) extra++;
    end
    chk({tag, ".quiet"}, extra, 0);
  endtask

  logic [7:0] chase_seq [9] = '{8'h80, 8'h40, 8'h20, 8'h10, 8'h08,
                                8'h04, 8'h02, 8'h01, 8'h80};
  logic [7:0] auto_lamb [24];
  logic [1:0] auto_mode [24];

  initial begin
    // T1: reset state and fixed FLASH
    #12;
    chk("rst.lamb", lamb, 8'h00);
    chk("rst.mode", mode, 2'b01);
    chk("rst.tick", tick, 0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_tick("flash1", 4, 8'hFF, 2'b01);
    wait_tick("flash2", 4, 8'h00, 2'b01);
    wait_tick("flash3", 4, 8'hFF, 2'b01);

    // T2: fixed CHASE; a step_req while running must not add a tick
    mode_sel = 2'b10;
    for (int i = 0; i < 9; i++) begin
      wait_tick($sformatf("chase%0d", i), 4, chase_seq[i], 2'b10);
      if (i == 0) begin
        step_req = 1'b1;
        @(negedge clk);
        step_req = 1'b0;
        wait_tick("run_step", 3, 8'h40, 2'b10);
        i++;
      end
    end

    // T5: CHASE -> ALT mid-pass
    wait_tick("c40", 4, 8'h40, 2'b10);
    wait_tick("c20", 4, 8'h20, 2'b10);
    mode_sel = 2'b11;
    wait_tick("alt0", 4, 8'h55, 2'b11);
    wait_tick("alt1", 4, 8'hAA, 2'b11);

    // T4: pause with prescaler at 2, single steps, resume
    mode_sel = 2'b10;
    wait_tick("sw_chase", 4, 8'h80, 2'b10);
    @(negedge clk);
    @(negedge clk);
    run = 1'b0;
    step_once("step1", 8'h40);
    step_once("step2", 8'h20);
    step_once("step3", 8'h10);
    run = 1'b1;
    wait_tick("resume", 2, 8'h08, 2'b10);

    // T6: asynchronous reset between edges while showing 08
    chk("pre_rst.tick", tick, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst.lamb", lamb, 8'h00);
    chk("arst.mode", mode, 2'b01);
    chk("arst.tick", tick, 0);
    mode_sel = 2'b01;
    @(negedge clk);
    rst_n = 1'b1;
    wait_tick("post_rst", 4, 8'hFF, 2'b01);

    // T3: auto-rotation from reset
    for (int i = 0; i < 3; i++) begin
      auto_lamb[i] = (i % 2 == 0) ? 8'hFF : 8'h00;
      auto_mode[i] = 2'b01;
    end
    for (int i = 3; i < 19; i++) begin
      auto_lamb[i] = chase_seq[(i - 3) % 8];
      auto_mode[i] = 2'b10;
    end
    for (int i = 19; i < 23; i++) begin
      auto_lamb[i] = (i % 2 == 1) ? 8'h55 : 8'hAA;
      auto_mode[i] = 2'b11;
    end
    auto_lamb[23] = 8'h00;
    auto_mode[23] = 2'b01;
    mode_sel = 2'b00;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 24; i++)
      wait_tick($sformatf("auto%0d", i + 1), 4, auto_lamb[i], auto_mode[i]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
